// File: rtl/shift_link_pkg.sv
// Shared definitions for the serial shift link (receiver shift_deser and the
// matching shift_ser transmitter).
//   - FSM state encoding (2 bits)
//   - line-level constants for start, stop and idle
package shift_link_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DATA  = 2'd1;
    localparam logic [1:0] ST_STOP  = 2'd2;
    localparam logic [1:0] ST_BREAK = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        DATA  = ST_DATA,
        STOP  = ST_STOP,
        BREAK = ST_BREAK
    } state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/bit_counter.sv
// Up-counter with synchronous clear and count enable, plus a terminal-count
// flag that is high while the count equals W-1.
//   clk  : system clock
//   rst  : synchronous active-high reset (count -> 0)
//   clr  : synchronous clear, has priority over en
//   en   : increment by one
//   tc   : count == W-1
module bit_counter #(
    parameter int W  = 8,
    parameter int CW = $clog2(W)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CW'(W - 1));

endmodule

// File: rtl/shift_deser.sv
// Receiver of the serial shift link: rebuilds framed, MSB-first words and
// presents them on a valid/ready interface.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   ser_valid : bit strobe, ser_data sampled only when high
//   ser_data  : serial line (idles high)
//   par_data  : received word, stable while par_valid
//   par_valid : word available
//   par_ready : consumer accepts on par_valid & par_ready
//   frame_err : one-cycle pulse when a stop bit was 0
//   overrun   : sticky, a finished word was dropped because the holder was full
//
// state | meaning
// IDLE  | line idle, waiting for a strobed start bit (0)
// DATA  | shifting in W payload bits, MSB first
// STOP  | expecting the stop bit (1)
// BREAK | bad stop seen, waiting for the line to return to 1
module shift_deser
    import shift_link_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ser_valid,
    input  logic         ser_data,
    output logic [W-1:0] par_data,
    output logic         par_valid,
    input  logic         par_ready,
    output logic         frame_err,
    output logic         overrun
);

    state_e       state;
    logic [W-1:0] shift_reg;
    logic         cnt_clr;
    logic         cnt_en;
    logic         cnt_tc;
    logic         accept;

    // The counter is cleared on entry to DATA and again when the last bit is
    // taken, so it never runs past W-1 even for non power-of-two W.
    assign cnt_clr = ser_valid &
                     (((state == IDLE) && (ser_data == START_BIT)) ||
                      ((state == DATA) && cnt_tc));
    assign cnt_en  = ser_valid && (state == DATA);
    assign accept  = par_valid & par_ready;

    bit_counter #(
        .W  (W),
        .CW (CW)
    ) u_bit_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            par_data  <= '0;
            par_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (accept) begin
                par_valid <= 1'b0;
            end
            if (ser_valid) begin
                case (state)
                    IDLE: begin
                        if (ser_data == START_BIT) begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        shift_reg <= {shift_reg[W-2:0], ser_data};
                        if (cnt_tc) begin
                            state <= STOP;
                        end
                    end
                    STOP: begin
                        if (ser_data == STOP_BIT) begin
                            // A word being accepted this same edge frees the
                            // holder, so the new word replaces it without a bubble.
                            if (!par_valid || par_ready) begin
                                par_data  <= shift_reg;
                                par_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end
                    BREAK: begin
                        if (ser_data == STOP_BIT) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shift_deser.sv
module tb_shift_deser;
    import shift_link_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         ser_valid;
    logic         ser_data;
    logic [W-1:0] par_data;
    logic         par_valid;
    logic         par_ready;
    logic         frame_err;
    logic         overrun;

    int vectors    = 0;
    int miscompares = 0;
    int fe_count   = 0;
    logic [W-1:0] exp_q[$];

    shift_deser #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .par_data  (par_data),
        .par_valid (par_valid),
        .par_ready (par_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every handshake seen on the falling edge must match the
    // oldest expected word.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) fe_count++;
            if (par_valid && par_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL scoreboard_unexpected: got %h, required no word", par_data);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    if (par_data !== e) begin
                        miscompares++;
                        $display("FAIL scoreboard_data: got %h, required %h", par_data, e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One strobed bit followed by 'gap' idle cycles with random line noise.
    // With chk set, par_valid/par_data must not move during the gap.
    task automatic strobe_bit(input logic b, input int gap, input bit chk);
        logic         pv0;
        logic [W-1:0] pd0;
        pv0 = 1'b0;
        pd0 = '0;
        ser_valid = 1'b1;
        ser_data  = b;
        step();
        ser_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            ser_data = 1'($urandom_range(0, 1));
            if (g == 0) begin
                @(negedge clk);
                pv0 = par_valid;
                pd0 = par_data;
            end
            step();
            if (chk) begin
                @(negedge clk);
                vectors++;
                if (par_valid !== pv0 || par_data !== pd0) begin
                    miscompares++;
                    $display("FAIL sparse_hold: got v=%b d=%h, required v=%b d=%h",
                             par_valid, par_data, pv0, pd0);
                end
            end
        end
    endtask

    task automatic send_frame(input logic [W-1:0] word, input logic stop_bit,
                              input int gap, input bit chk);
        strobe_bit(START_BIT, gap, chk);
        for (int i = W - 1; i >= 0; i--) strobe_bit(word[i], gap, chk);
        strobe_bit(stop_bit, gap, chk);
        ser_data = IDLE_LEVEL;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        vectors++;
        if (par_valid !== 1'b0 || par_data !== '0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values: got v=%b d=%h fe=%b ov=%b, required all 0",
                     par_valid, par_data, frame_err, overrun);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_a5();
        par_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, STOP_BIT, 0, 1'b0);
        @(negedge clk);
        vectors++;
        if (par_valid !== 1'b1 || par_data !== 8'hA5 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL a5_latency: got v=%b d=%h fe=%b ov=%b, required v=1 d=a5 fe=0 ov=0",
                     par_valid, par_data, frame_err, overrun);
        end
        step();
        step();
    endtask

    task automatic test_sparse();
        par_ready = 1'b0;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, STOP_BIT, 2, 1'b1);
        @(negedge clk);
        vectors++;
        if (par_valid !== 1'b1 || par_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL sparse_word: got v=%b d=%h, required v=1 d=a5", par_valid, par_data);
        end
        step();
        par_ready = 1'b1;
        step();
        step();
    endtask

    task automatic test_frame_err();
        par_ready = 1'b1;
        fe_count  = 0;
        send_frame(8'h3C, 1'b0, 0, 1'b0);
        @(negedge clk);
        vectors++;
        if (frame_err !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_err_pulse: got %b, required 1", frame_err);
        end
        step();
        for (int i = 0; i < 4; i++) strobe_bit(1'b0, 0, 1'b0);
        strobe_bit(1'b1, 0, 1'b0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, STOP_BIT, 0, 1'b0);
        repeat (3) step();
        vectors++;
        if (fe_count !== 1) begin
            miscompares++;
            $display("FAIL frame_err_width: got %0d cycles, required 1", fe_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w;
        par_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = W'($urandom);
            exp_q.push_back(w);
            send_frame(w, STOP_BIT, 0, 1'b0);
        end
        repeat (3) step();
    endtask

    task automatic test_simultaneous();
        par_ready = 1'b0;
        exp_q.push_back(8'h55);
        send_frame(8'h55, STOP_BIT, 0, 1'b0);
        step();
        exp_q.push_back(8'hAA);
        strobe_bit(START_BIT, 0, 1'b0);
        for (int i = W - 1; i >= 0; i--) strobe_bit(((i % 2) == 1), 0, 1'b0);
        par_ready = 1'b1;
        strobe_bit(STOP_BIT, 0, 1'b0);
        ser_data = IDLE_LEVEL;
        @(negedge clk);
        vectors++;
        if (par_valid !== 1'b1 || par_data !== 8'hAA || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL simultaneous: got v=%b d=%h ov=%b, required v=1 d=aa ov=0",
                     par_valid, par_data, overrun);
        end
        step();
        step();
    endtask

    task automatic test_overrun();
        par_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, STOP_BIT, 0, 1'b0);
        @(negedge clk);
        vectors++;
        if (par_valid !== 1'b1 || par_data !== 8'h11 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_first: got v=%b d=%h ov=%b, required v=1 d=11 ov=0",
                     par_valid, par_data, overrun);
        end
        send_frame(8'h22, STOP_BIT, 0, 1'b0);
        @(negedge clk);
        vectors++;
        if (par_valid !== 1'b1 || par_data !== 8'h11 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set: got v=%b d=%h ov=%b, required v=1 d=11 ov=1",
                     par_valid, par_data, overrun);
        end
        step();
        par_ready = 1'b1;
        step();
        @(negedge clk);
        vectors++;
        if (par_valid !== 1'b0 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_sticky: got v=%b ov=%b, required v=0 ov=1", par_valid, overrun);
        end
        step();
    endtask

    task automatic test_reset_midframe();
        par_ready = 1'b1;
        strobe_bit(START_BIT, 0, 1'b0);
        for (int i = 0; i < 4; i++) strobe_bit(1'b1, 0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (par_valid !== 1'b0 || overrun !== 1'b0 || frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL midframe_reset: got v=%b ov=%b fe=%b, required all 0",
                     par_valid, overrun, frame_err);
        end
        exp_q.push_back(8'hF0);
        send_frame(8'hF0, STOP_BIT, 0, 1'b0);
        @(negedge clk);
        vectors++;
        if (par_valid !== 1'b1 || par_data !== 8'hF0 || overrun !== 1'b0 || frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL midframe_word: got v=%b d=%h ov=%b fe=%b, required v=1 d=f0 ov=0 fe=0",
                     par_valid, par_data, overrun, frame_err);
        end
        step();
    endtask

    initial begin
        rst       = 1'b1;
        ser_valid = 1'b0;
        ser_data  = IDLE_LEVEL;
        par_ready = 1'b0;
        test_reset();
        test_a5();
        test_sparse();
        test_frame_err();
        test_back_to_back();
        test_simultaneous();
        test_overrun();
        test_reset_midframe();
        par_ready = 1'b1;
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) step();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d words outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
